// File: rtl/axis_mem_port_frontend_if.sv
// Client + crossbar-port signal bundle for one memory port front end.
// slave is the front end's view, master is the surrounding client/crossbar.
interface axis_mem_port_frontend_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = 4
);
  logic                  cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr, cmd_beats;
  logic                  s_tvalid, s_tready;
  logic [DATA_WIDTH-1:0] s_tdata;
  logic [STRB_WIDTH-1:0] s_tstrb;
  logic                  m_tvalid, m_tready, m_tlast;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  x_avalid, x_aready, x_arnw;
  logic [ADDR_WIDTH-1:0] x_aaddr, x_abeats;
  logic                  x_wvalid, x_wready, x_wlast;
  logic [DATA_WIDTH-1:0] x_wdata;
  logic [STRB_WIDTH-1:0] x_wstrb;
  logic                  x_rvalid, x_rready, x_rlast;
  logic [DATA_WIDTH-1:0] x_rdata;
  logic                  done, error;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_beats, s_tvalid, s_tdata, s_tstrb,
           m_tready, x_aready, x_wready, x_rvalid, x_rdata, x_rlast,
    output cmd_ready, s_tready, m_tvalid, m_tdata, m_tlast, x_avalid, x_arnw,
           x_aaddr, x_abeats, x_wvalid, x_wdata, x_wstrb, x_wlast, x_rready, done, error
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_beats, s_tvalid, s_tdata, s_tstrb,
           m_tready, x_aready, x_wready, x_rvalid, x_rdata, x_rlast,
    input  cmd_ready, s_tready, m_tvalid, m_tdata, m_tlast, x_avalid, x_arnw,
           x_aaddr, x_abeats, x_wvalid, x_wdata, x_wstrb, x_wlast, x_rready, done, error
  );
endinterface

// File: rtl/axis_mem_port_frontend.sv
// Single-command front end for one crossbar port: address request, write pass-through,
// read data buffered in a first-word-fall-through FIFO with a generated last tag.
module axis_mem_port_frontend #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int STRB_WIDTH      = 4,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                      aclk,
  input  logic                      resetn,
  axis_mem_port_frontend_if.slave   bus
);
  localparam int L     = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << L;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [L-1:0]          PTR_ONE = 1;
  localparam logic [L:0]            OCC_ONE = 1;

  typedef enum logic [2:0] {IDLE, ADDR, WRITE, READ, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q, beats_q, cnt;
  logic                  wr_q, err_q;
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [L-1:0]          wr_ptr, rd_ptr;
  logic [L:0]            occ;
  logic                  full, empty, push, pop, wr_hs, last_beat;

  assign last_beat = (cnt == beats_q - CNT_ONE);
  assign full      = occ[L];
  assign empty     = (occ == '0);
  assign push      = bus.x_rvalid && bus.x_rready;
  assign pop       = bus.m_tvalid && bus.m_tready;
  assign wr_hs     = bus.x_wvalid && bus.x_wready;

  assign bus.x_arnw   = wr_q;
  assign bus.x_aaddr  = addr_q;
  assign bus.x_abeats = beats_q;
  assign bus.error    = err_q;
  assign bus.x_wdata  = bus.s_tdata;
  assign bus.x_wstrb  = bus.s_tstrb;
  assign bus.m_tvalid = !empty;
  assign bus.m_tdata  = mem[rd_ptr][DATA_WIDTH-1:0];
  assign bus.m_tlast  = !empty && mem[rd_ptr][DATA_WIDTH];

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.x_avalid  = 1'b0;
    bus.x_wvalid  = 1'b0;
    bus.s_tready  = 1'b0;
    bus.x_wlast   = 1'b0;
    bus.x_rready  = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nxt = (bus.cmd_beats == '0) ? DONE : ADDR;
      end
      ADDR: begin
        bus.x_avalid = 1'b1;
        if (bus.x_aready) state_nxt = wr_q ? WRITE : READ;
      end
      WRITE: begin
        bus.x_wvalid = bus.s_tvalid;
        bus.s_tready = bus.x_wready;
        bus.x_wlast  = last_beat;
        if (bus.s_tvalid && bus.x_wready && last_beat) state_nxt = DONE;
      end
      READ: begin
        // stop accepting once every counted beat is in, so the counter never overruns
        bus.x_rready = !full && (cnt != beats_q);
        if (bus.m_tvalid && bus.m_tready && bus.m_tlast) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state   <= IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      cnt     <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.cmd_valid) begin
        addr_q  <= bus.cmd_addr;
        beats_q <= bus.cmd_beats;
        wr_q    <= bus.cmd_write;
        cnt     <= '0;
        err_q   <= (bus.cmd_beats == '0);
      end
      if (wr_hs) cnt <= cnt + CNT_ONE;
      if (push) begin
        cnt    <= cnt + CNT_ONE;
        wr_ptr <= wr_ptr + PTR_ONE;
        if (bus.x_rlast != last_beat) err_q <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= {last_beat, bus.x_rdata};
  end
endmodule

// File: tb/tb_axis_mem_port_frontend.sv
// Directed + randomized bench for axis_mem_port_frontend with a beat-level reference model.
module tb_axis_mem_port_frontend;
  localparam int DW = 32, AW = 32, SW = 4, DEPTH = 16;

  logic aclk, resetn;
  int   n_chk, n_fail;

  axis_mem_port_frontend_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) bus ();

  axis_mem_port_frontend #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .FIFO_DEPTH_LOG2(4)
  ) dut (
    .aclk(aclk), .resetn(resetn), .bus(bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_beats = 0;
    bus.s_tvalid = 0;  bus.s_tdata = 0;   bus.s_tstrb = 0;  bus.m_tready = 0;
    bus.x_aready = 0;  bus.x_wready = 0;  bus.x_rvalid = 0; bus.x_rdata = 0; bus.x_rlast = 0;
  endtask

  task automatic issue_cmd(input bit w, input logic [31:0] addr, input logic [31:0] beats);
    @(negedge aclk);
    drive_idle();
    bus.cmd_valid = 1; bus.cmd_write = w; bus.cmd_addr = addr; bus.cmd_beats = beats;
    #1;
    chk("cmd_ready", bus.cmd_ready, 1);
  endtask

  // Address phase; data-side valids are held high to prove nothing moves here.
  task automatic addr_phase(input bit w, input logic [31:0] addr, input logic [31:0] beats,
                            input int delay);
    for (int c = 0; c <= delay; c++) begin
      @(negedge aclk);
      bus.cmd_valid = 0; bus.x_aready = (c == delay);
      bus.s_tvalid = 1;  bus.x_wready = 1; bus.x_rvalid = 1;
      #1;
      chk("x_avalid_hold", bus.x_avalid, 1);
      chk("x_arnw", bus.x_arnw, w);
      chk("x_aaddr", bus.x_aaddr, addr);
      chk("x_abeats", bus.x_abeats, beats);
      chk("addr_no_wvalid", bus.x_wvalid, 0);
      chk("addr_no_rready", bus.x_rready, 0);
      chk("addr_no_tready", bus.s_tready, 0);
      chk("addr_cmd_ready", bus.cmd_ready, 0);
      if (c == 0) chk("err_clear_on_accept", bus.error, 0);
    end
  endtask

  task automatic done_phase(input bit err_exp);
    @(negedge aclk);
    bus.s_tvalid = 1; bus.x_wready = 1; bus.x_rvalid = 0; bus.m_tready = 1;
    #1;
    chk("done_pulse", bus.done, 1);
    chk("done_no_wvalid", bus.x_wvalid, 0);
    chk("done_no_mvalid", bus.m_tvalid, 0);
    chk("done_cmd_ready", bus.cmd_ready, 0);
    chk("done_error", bus.error, err_exp);
    @(negedge aclk);
    bus.s_tvalid = 0;
    #1;
    chk("done_one_cycle", bus.done, 0);
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_error", bus.error, err_exp);
  endtask

  task automatic write_data(input int beats, input int p_v, input int p_r, input bit toggle);
    int k = 0, cyc = 0;
    bit v, r;
    logic [31:0] d;
    logic [3:0]  s;
    while (k < beats && cyc < 4000) begin
      @(negedge aclk);
      bus.x_aready = 0;
      v = ($urandom_range(99) < p_v);
      r = toggle ? (cyc % 2 == 0) : ($urandom_range(99) < p_r);
      d = $urandom; s = 4'($urandom);
      bus.s_tvalid = v; bus.x_wready = r; bus.s_tdata = d; bus.s_tstrb = s;
      #1;
      chk("wr_avalid_low", bus.x_avalid, 0);
      chk("wr_no_rready", bus.x_rready, 0);
      chk("x_wvalid", bus.x_wvalid, v);
      chk("s_tready", bus.s_tready, r);
      chk("wr_no_done", bus.done, 0);
      if (v) begin
        chk("x_wdata", bus.x_wdata, d);
        chk("x_wstrb", bus.x_wstrb, s);
        chk("x_wlast", bus.x_wlast, (k == beats - 1));
      end
      if (v && r) k++;
      cyc++;
    end
    chk("wr_beat_count", k, beats);
    done_phase(0);
  endtask

  // Model: pushed i, popped j; occupancy is i-j, the head is src[j].
  task automatic read_data(input int beats, input int bad_idx, input int stall,
                           input int p_rv, input int p_mr, input bit check_full);
    logic [31:0] src[$];
    int i = 0, j = 0, cyc = 0;
    bit err_exp = 0, rv, mr;
    for (int n = 0; n < beats; n++) src.push_back($urandom);
    while (j < beats && cyc < 4000) begin
      @(negedge aclk);
      bus.x_aready = 0;
      rv = (i < beats) && ($urandom_range(99) < p_rv);
      mr = (cyc >= stall) && ($urandom_range(99) < p_mr);
      bus.x_rvalid = rv;
      bus.x_rdata  = (i < beats) ? src[i] : 32'h0;
      bus.x_rlast  = rv && ((bad_idx >= 0) ? (i == bad_idx) : (i == beats - 1));
      bus.m_tready = mr;
      #1;
      chk("rd_error", bus.error, err_exp);
      chk("rd_no_wvalid", bus.x_wvalid, 0);
      chk("rd_no_done", bus.done, 0);
      if (i < beats) chk("x_rready", bus.x_rready, (i - j < DEPTH));
      chk("m_tvalid", bus.m_tvalid, (i > j));
      if (i > j) begin
        chk("m_tdata", bus.m_tdata, src[j]);
        chk("m_tlast", bus.m_tlast, (j == beats - 1));
      end
      if (rv && bus.x_rready) begin
        if (bus.x_rlast != (i == beats - 1)) err_exp = 1;
        i++;
      end
      if (bus.m_tvalid && mr) j++;
      if (check_full && cyc == stall - 1) chk("fifo_fill_level", i, DEPTH);
      cyc++;
    end
    chk("rd_beat_count", j, beats);
    done_phase(err_exp);
  endtask

  initial begin
    bit w;
    int beats;
    logic [31:0] addr;
    n_chk = 0; n_fail = 0;
    resetn = 0;
    drive_idle();
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_x_avalid", bus.x_avalid, 0);
    chk("rst_x_wvalid", bus.x_wvalid, 0);
    chk("rst_x_rready", bus.x_rready, 0);
    chk("rst_s_tready", bus.s_tready, 0);
    chk("rst_m_tvalid", bus.m_tvalid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_x_aaddr", bus.x_aaddr, 0);
    chk("rst_x_abeats", bus.x_abeats, 0);
    chk("rst_x_arnw", bus.x_arnw, 0);
    @(negedge aclk);
    resetn = 1;

    // write 4 beats, aready pulse after two wait cycles
    issue_cmd(1, 32'h1000, 4);
    addr_phase(1, 32'h1000, 4, 2);
    write_data(4, 100, 100, 0);

    // read 20 beats with a 30-cycle downstream stall: FIFO fills to 16
    issue_cmd(0, 32'h2000, 20);
    addr_phase(0, 32'h2000, 20, 1);
    read_data(20, -1, 30, 100, 100, 1);

    // read 3 beats with x_rlast on beat 2
    issue_cmd(0, 32'h3000, 3);
    addr_phase(0, 32'h3000, 3, 0);
    read_data(3, 1, 0, 100, 100, 0);

    // write 8 beats with toggling x_wready and s_tvalid gaps
    issue_cmd(1, 32'h4000, 8);
    addr_phase(1, 32'h4000, 8, 3);
    write_data(8, 70, 0, 1);

    // zero-beat command
    issue_cmd(1, 32'h5000, 0);
    @(negedge aclk);
    bus.cmd_valid = 0;
    #1;
    chk("zero_no_avalid", bus.x_avalid, 0);
    chk("zero_done", bus.done, 1);
    chk("zero_error", bus.error, 1);
    @(negedge aclk);
    #1;
    chk("zero_done_once", bus.done, 0);
    chk("zero_no_avalid2", bus.x_avalid, 0);
    chk("zero_cmd_ready", bus.cmd_ready, 1);
    chk("zero_error_sticky", bus.error, 1);

    // reset during a read with 5 entries buffered
    issue_cmd(0, 32'h6000, 10);
    addr_phase(0, 32'h6000, 10, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      bus.x_aready = 0; bus.x_rvalid = 1; bus.x_rdata = 32'(c + 1); bus.x_rlast = 0;
      bus.m_tready = 0; bus.s_tvalid = 0;
      #1;
      chk("mid_rready", bus.x_rready, 1);
    end
    @(negedge aclk);
    bus.x_rvalid = 0;
    resetn = 0;
    #1;
    chk("mid_buffered", bus.m_tvalid, 1);
    @(negedge aclk);
    resetn = 1;
    #1;
    chk("mid_rst_mvalid", bus.m_tvalid, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_rready", bus.x_rready, 0);
    @(negedge aclk);
    #1;
    chk("mid_rst_no_done", bus.done, 0);
    issue_cmd(0, 32'h7000, 6);
    addr_phase(0, 32'h7000, 6, 1);
    read_data(6, -1, 0, 90, 80, 0);

    // randomized commands
    for (int t = 0; t < 12; t++) begin
      w     = 1'($urandom);
      beats = $urandom_range(1, 24);
      addr  = $urandom & 32'hFFFF_FFFC;
      issue_cmd(w, addr, beats);
      addr_phase(w, addr, beats, $urandom_range(0, 3));
      if (w) write_data(beats, 80, 70, 0);
      else   read_data(beats, -1, $urandom_range(0, 20), 80, 60, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_mem_port_frontend.md
Name: axis_mem_port_frontend

Overview:
- Per-client front end that drives one port of the AXI-stream-to-AXI memory crossbar.
- Accepts a single command (read or write, address, beat count). Issues the crossbar address request and moves the data.
  - Writes: forwards an upstream stream and generates the write last flag internally.
  - Reads: buffers crossbar read data in a small FIFO and presents it downstream with a generated tlast.
- Reports completion and a protocol error flag. Sits between a client (rasterizer or framebuffer unit) and one crossbar port.

Parameters:
- DATA_WIDTH, 32, data bus width of the stream and crossbar port.
- ADDR_WIDTH, 32, width of address and beat count.
- STRB_WIDTH, 4, byte strobe width (DATA_WIDTH/8).
- FIFO_DEPTH_LOG2, 4, log2 of read FIFO depth (16 entries).

Ports:
- aclk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_write  in  1  1=write to memory, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte start address.
- cmd_beats  in  ADDR_WIDTH  number of data beats.
- s_tvalid / s_tready  in/out  1  write data handshake from client.
- s_tdata  in  DATA_WIDTH  write data.
- s_tstrb  in  STRB_WIDTH  write byte strobes.
- m_tvalid / m_tready  out/in  1  read data handshake to client.
- m_tdata  out  DATA_WIDTH  read data.
- m_tlast  out  1  final read beat.
- x_avalid / x_aready  out/in  1  crossbar address handshake; x_aready may be a one-cycle pulse.
- x_arnw  out  1  0=read, 1=write.
- x_aaddr  out  ADDR_WIDTH  address to crossbar.
- x_abeats  out  ADDR_WIDTH  beats to crossbar.
- x_wvalid / x_wready  out/in  1  crossbar write data handshake.
- x_wdata  out  DATA_WIDTH  write data.
- x_wstrb  out  STRB_WIDTH  write strobes.
- x_wlast  out  1  final write beat.
- x_rvalid / x_rready  in/out  1  crossbar read data handshake.
- x_rdata  in  DATA_WIDTH  read data.
- x_rlast  in  1  crossbar read last.
- done  out  1  one-cycle pulse at command completion.
- error  out  1  sticky protocol/command error.

Behaviour:
- Reset: state IDLE; beat counter 0; FIFO empty. Outputs after reset:
  - cmd_ready=1.
  - x_avalid, x_wvalid, x_rready, s_tready, m_tvalid, done, error = 0.
  - x_aaddr, x_abeats, x_arnw = 0.
- FSM states IDLE, ADDR, WRITE, READ, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch address, beats and direction; clear error; counter=0.
  - cmd_beats==0: go to DONE with error<=1; no address request.
  - Otherwise go to ADDR. x_avalid rises the cycle after acceptance.
- ADDR:
  - Hold x_avalid/x_arnw/x_aaddr/x_abeats stable until x_aready=1.
  - Then deassert x_avalid the next cycle and go to WRITE or READ.
  - No data moves in ADDR: x_wvalid=0, x_rready=0.
- WRITE (combinational pass-through, zero latency):
  - x_wvalid=s_tvalid; s_tready=x_wready; x_wdata=s_tdata; x_wstrb=s_tstrb.
  - x_wlast=(counter==beats-1).
  - Counter increments per x_wvalid&&x_wready.
  - Final beat accepted: go to DONE.
- READ:
  - x_rready=!fifo_full. Each x_rvalid&&x_rready pushes x_rdata plus a last tag (counter==beats-1); counter increments.
  - x_rlast on a non-final beat, or final beat without x_rlast: error<=1. Counting continues; transfer still ends on the counted final beat.
  - m_tvalid=!fifo_empty; m_tdata/m_tlast come from the FIFO head (first-word-fall-through).
  - Simultaneous push and pop when full or empty is allowed; occupancy stays consistent.
  - Go to DONE when the tagged last entry pops (m_tvalid&&m_tready&&m_tlast).
- DONE: done=1 for exactly one cycle, then IDLE. Earliest next cmd_ready is the cycle after done.
- Beat counter and beats are ADDR_WIDTH wide; no wrap for beats ≤ 2^ADDR_WIDTH-1.
- Reset mid-transfer: return to reset state immediately; FIFO flushed; no done pulse.
- error holds until the next command is accepted.

Test Plan:
- Write cmd addr=0x1000 beats=4, s_tdata 1..4, x_wready=1, single-cycle x_aready pulse -> x_avalid held until pulse, x_arnw=1, x_abeats=4; 4 beats forwarded; x_wlast only on data 4; done one cycle after the 4th handshake; error=0.
- Read cmd addr=0x2000 beats=20, m_tready=0 for 30 cycles -> x_rready drops after 16 FIFO entries, no data lost; after release, m_tdata 1..20 in order, m_tlast only on beat 20, then done.
- Read beats=3, x_rlast asserted on beat 2 -> error=1 after beat 2; 3 beats delivered; m_tlast on beat 3; done; error cleared on the next cmd acceptance.
- cmd_beats=0 -> no x_avalid, done pulse 1 cycle after acceptance, error=1.
- Write with x_wready toggling 1/0 and s_tvalid gaps, beats=8 -> exactly 8 handshakes, counter matches, x_wlast on 8th only.
- resetn low during READ with 5 entries in FIFO -> m_tvalid=0, cmd_ready=1 after reset, no done pulse, new command runs normally.
